// File: rtl/vending_machine_change_fsm_pkg.sv
// Shared types, coin/change denominations and denomination helpers for the
// vending controller and its change dispenser.
package vending_machine_change_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VEND,
        CHANGE,
        REFUND
    } state_t;

    typedef enum logic [1:0] {
        COIN_1,
        COIN_2,
        COIN_5,
        COIN_10
    } coin_idx_t;

    localparam int COIN_VAL [4] = '{1, 2, 5, 10};
    localparam int CHG_VAL  [3] = '{1, 2, 5};

    function automatic int coin_value(input logic [3:0] coin);
        int v;
        v = 0;
        for (int i = 0; i < 4; i++) begin
            if (coin[i]) v = COIN_VAL[i];
        end
        return v;
    endfunction

    function automatic int chg_value(input logic [2:0] req);
        int v;
        v = 0;
        for (int i = 0; i < 3; i++) begin
            if (req[i]) v = CHG_VAL[i];
        end
        return v;
    endfunction

    // Greedy payout: the largest hopper coin that still fits in what is owed.
    function automatic logic [2:0] largest_chg(input int remain);
        logic [2:0] req;
        req = 3'b000;
        if (remain >= CHG_VAL[2])      req = 3'b100;
        else if (remain >= CHG_VAL[1]) req = 3'b010;
        else if (remain >= CHG_VAL[0]) req = 3'b001;
        return req;
    endfunction

endpackage

// File: rtl/vending_machine_change_fsm_if.sv
// Coin acceptor / item actuator / change hopper signal bundle.
// The master side drives coins, cancel, restock and hopper acks.
interface vending_machine_change_fsm_if #(
    parameter int STOCK_W = 4,
    parameter int CRED_W  = 4
);
    logic [3:0]         coin_in;
    logic               cancel;
    logic               restock;
    logic [STOCK_W-1:0] restock_qty;
    logic [2:0]         chg_ack;
    logic               give_candy;
    logic [2:0]         chg_req;
    logic               coin_reject;
    logic [CRED_W-1:0]  credit;
    logic               sold_out;

    modport master (
        output coin_in, cancel, restock, restock_qty, chg_ack,
        input  give_candy, chg_req, coin_reject, credit, sold_out
    );

    modport slave (
        input  coin_in, cancel, restock, restock_qty, chg_ack,
        output give_candy, chg_req, coin_reject, credit, sold_out
    );
endinterface

// File: rtl/vending_machine_change_fsm_dispenser.sv
// Pays out an owed amount coin by coin over the hopper req/ack handshake.
// Used for both post-vend change and cancel refunds.
module vending_machine_change_fsm_dispenser
    import vending_machine_change_fsm_pkg::*;
#(
    parameter int CRED_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [CRED_W-1:0] load_val_i,
    input  logic              active_i,
    input  logic [2:0]        chg_ack_i,
    output logic [2:0]        chg_req_o,
    output logic [CRED_W-1:0] remain_o,
    output logic              done_o
);

    logic [CRED_W-1:0] remain_q;
    logic [2:0]        chg_req_q;

    // A request is held until its exact ack, then dropped for one cycle
    // before the next denomination is chosen from the reduced balance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remain_q  <= '0;
            chg_req_q <= 3'b000;
        end else if (load_i) begin
            remain_q  <= load_val_i;
            chg_req_q <= 3'b000;
        end else if (active_i) begin
            if (chg_req_q != 3'b000) begin
                if (chg_ack_i == chg_req_q) begin
                    remain_q  <= remain_q - CRED_W'(chg_value(chg_req_q));
                    chg_req_q <= 3'b000;
                end
            end else if (remain_q != '0) begin
                chg_req_q <= largest_chg(int'(remain_q));
            end
        end
    end

    assign chg_req_o = chg_req_q;
    assign remain_o  = remain_q;
    assign done_o    = (remain_q == '0);

endmodule

// File: rtl/vending_machine_change_fsm.sv
// Vending controller: credit accumulation, single-item vend, stock tracking,
// with change and refunds delegated to the dispenser.
module vending_machine_change_fsm
    import vending_machine_change_fsm_pkg::*;
#(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8
) (
    input logic                    clk,
    input logic                    rst,
    vending_machine_change_fsm_if.slave bus
);

    localparam int CRED_W    = $clog2(MAX_CREDIT + 1);
    localparam int SUM_W     = CRED_W + 4;
    localparam int STK_SUM_W = STOCK_W + 2;
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

    state_t              state_q;
    logic [CRED_W-1:0]   credit_q;
    logic [STOCK_W-1:0]  stock_q;
    logic                give_candy_q;
    logic                coin_reject_q;

    logic [SUM_W-1:0]     sum_d;
    logic [STK_SUM_W-1:0] stock_sum;
    logic [STOCK_W-1:0]   stock_d;
    logic [CRED_W-1:0]    load_val;
    logic [CRED_W-1:0]    remain;
    logic [2:0]           chg_req;
    logic                 coin_present;
    logic                 coin_ok;
    logic                 sold_out;
    logic                 cancel_hit;
    logic                 load_en;
    logic                 disp_active;
    logic                 disp_done;

    // Sums are formed wider than their registers so limits are checked before commit.
    always_comb begin
        sold_out     = (stock_q == '0);
        coin_present = |bus.coin_in;
        sum_d        = SUM_W'(credit_q) + SUM_W'(coin_value(bus.coin_in));
        coin_ok      = $onehot(bus.coin_in) && !sold_out && (sum_d <= SUM_W'(MAX_CREDIT));
        cancel_hit   = (state_q == IDLE) && bus.cancel && (credit_q != '0);
        load_en      = cancel_hit || ((state_q == VEND) && (credit_q > CRED_W'(PRICE)));
        load_val     = cancel_hit ? credit_q : credit_q - CRED_W'(PRICE);
        disp_active  = (state_q == CHANGE) || (state_q == REFUND);
        stock_sum    = STK_SUM_W'(stock_q)
                     + (bus.restock ? STK_SUM_W'(bus.restock_qty) : STK_SUM_W'(0))
                     - ((state_q == VEND) ? STK_SUM_W'(1) : STK_SUM_W'(0));
        stock_d      = (stock_sum > STK_SUM_W'(STOCK_MAX)) ? STOCK_MAX : stock_sum[STOCK_W-1:0];
    end

    // Cancel outranks a coin arriving in the same cycle; that coin is bounced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            stock_q       <= STOCK_W'(INIT_STOCK);
            give_candy_q  <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            give_candy_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            stock_q       <= stock_d;
            case (state_q)
                IDLE: begin
                    if (bus.cancel) begin
                        coin_reject_q <= coin_present;
                        if (cancel_hit) begin
                            state_q  <= REFUND;
                            credit_q <= '0;
                        end
                    end else if (coin_present) begin
                        if (coin_ok) begin
                            credit_q <= sum_d[CRED_W-1:0];
                            if (sum_d >= SUM_W'(PRICE)) state_q <= VEND;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    give_candy_q  <= 1'b1;
                    coin_reject_q <= coin_present;
                    credit_q      <= '0;
                    state_q       <= load_en ? CHANGE : IDLE;
                end
                CHANGE, REFUND: begin
                    coin_reject_q <= coin_present;
                    if (disp_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    vending_machine_change_fsm_dispenser #(
        .CRED_W (CRED_W)
    ) u_dispenser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_en),
        .load_val_i (load_val),
        .active_i   (disp_active),
        .chg_ack_i  (bus.chg_ack),
        .chg_req_o  (chg_req),
        .remain_o   (remain),
        .done_o     (disp_done)
    );

    assign bus.give_candy  = give_candy_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.chg_req     = chg_req;
    assign bus.credit      = disp_active ? remain : credit_q;
    assign bus.sold_out    = sold_out;

endmodule

// File: tb/tb_vending_machine_change_fsm.sv
// Randomised and directed bench for vending_machine_change_fsm, checked
// against a transaction-level model that keeps owed change as a coin queue.
module tb_vending_machine_change_fsm;

    localparam int PRICE      = 12;
    localparam int MAX_CREDIT = 15;
    localparam int STOCK_W    = 4;
    localparam int INIT_STOCK = 1;
    localparam int CRED_W     = 4;
    localparam int STOCK_MAX  = 15;

    typedef enum {M_IDLE, M_VEND, M_PAY} mphase_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vending_machine_change_fsm_if #(.STOCK_W(STOCK_W), .CRED_W(CRED_W)) bus ();

    vending_machine_change_fsm #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int errorCount = 0;

    mphase_t mPhase;
    int      mCredit;
    int      mStock;
    int      payQ[$];
    bit      mGap;
    int      expGive;
    int      expReject;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int coinVal(input logic [3:0] c);
        case (c)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 5;
            4'b1000: return 10;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] chgCode(input int v);
        case (v)
            5:       return 3'b100;
            2:       return 3'b010;
            1:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int expCredit();
        int s;
        s = 0;
        if (mPhase != M_PAY) return mCredit;
        foreach (payQ[i]) s += payQ[i];
        return s;
    endfunction

    function automatic logic [2:0] expReq();
        if (mPhase == M_PAY && !mGap && payQ.size() > 0) return chgCode(payQ[0]);
        return 3'b000;
    endfunction

    task automatic modelReset();
        mPhase    = M_IDLE;
        mCredit   = 0;
        mStock    = INIT_STOCK;
        payQ.delete();
        mGap      = 1'b0;
        expGive   = 0;
        expReject = 0;
    endtask

    // Owed amount becomes a list of greedy coins; the first request follows a one-cycle gap.
    task automatic startPay(input int amount);
        int v;
        v = amount;
        payQ.delete();
        while (v >= 5) begin payQ.push_back(5); v -= 5; end
        while (v >= 2) begin payQ.push_back(2); v -= 2; end
        while (v >= 1) begin payQ.push_back(1); v -= 1; end
        mPhase = M_PAY;
        mGap   = 1'b1;
    endtask

    task automatic modelStep(input logic [3:0] coin, input bit cancel, input bit restock,
                             input int qty, input logic [2:0] ack);
        int s;
        int v;
        expGive   = 0;
        expReject = 0;
        s = mStock + (restock ? qty : 0) - ((mPhase == M_VEND) ? 1 : 0);
        if (s > STOCK_MAX) s = STOCK_MAX;
        case (mPhase)
            M_IDLE: begin
                if (cancel) begin
                    if (coin != 4'b0000) expReject = 1;
                    if (mCredit > 0) begin
                        startPay(mCredit);
                        mCredit = 0;
                    end
                end else if (coin != 4'b0000) begin
                    v = coinVal(coin);
                    if ($countones(coin) != 1 || mStock == 0 || mCredit + v > MAX_CREDIT) begin
                        expReject = 1;
                    end else begin
                        mCredit += v;
                        if (mCredit >= PRICE) mPhase = M_VEND;
                    end
                end
            end
            M_VEND: begin
                expGive = 1;
                if (coin != 4'b0000) expReject = 1;
                v = mCredit - PRICE;
                mCredit = 0;
                if (v > 0) startPay(v);
                else mPhase = M_IDLE;
            end
            default: begin
                if (coin != 4'b0000) expReject = 1;
                if (payQ.size() == 0) mPhase = M_IDLE;
                else if (mGap) mGap = 1'b0;
                else if (ack == chgCode(payQ[0])) begin
                    payQ.delete(0);
                    mGap = 1'b1;
                end
            end
        endcase
        mStock = s;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, " credit"},      int'(bus.credit),      expCredit());
        checkOutput({tag, " chg_req"},     int'(bus.chg_req),     int'(expReq()));
        checkOutput({tag, " give_candy"},  int'(bus.give_candy),  expGive);
        checkOutput({tag, " coin_reject"}, int'(bus.coin_reject), expReject);
        checkOutput({tag, " sold_out"},    int'(bus.sold_out),    (mStock == 0) ? 1 : 0);
    endtask

    task automatic applyStimulus(input logic [3:0] coin, input bit cancel, input bit restock,
                                 input logic [3:0] qty, input logic [2:0] ack, input string tag);
        bus.coin_in     = coin;
        bus.cancel      = cancel;
        bus.restock     = restock;
        bus.restock_qty = qty;
        bus.chg_ack     = ack;
        @(posedge clk);
        #1;
        modelStep(coin, cancel, restock, int'(qty), ack);
        compareAll(tag);
    endtask

    task automatic drainPayout(input string tag);
        for (int i = 0; i < 20 && mPhase != M_IDLE; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 4'd0, expReq(), tag);
        end
        checkOutput({tag, " back to idle"}, (mPhase == M_IDLE) ? 1 : 0, 1);
    endtask

    initial begin
        logic [3:0] coin;
        logic [2:0] ack;
        bit         cancel;
        bit         restock;
        logic [3:0] qty;

        bus.coin_in     = 4'b0000;
        bus.cancel      = 1'b0;
        bus.restock     = 1'b0;
        bus.restock_qty = '0;
        bus.chg_ack     = 3'b000;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset credit",      int'(bus.credit),      0);
        checkOutput("reset chg_req",     int'(bus.chg_req),     0);
        checkOutput("reset give_candy",  int'(bus.give_candy),  0);
        checkOutput("reset coin_reject", int'(bus.coin_reject), 0);
        checkOutput("reset sold_out",    int'(bus.sold_out),    0);
        rst = 1'b1;

        $display("[TB] directed vend with change");
        applyStimulus(4'b1000, 0, 0, 4'd0, 3'b000, "coin10");
        applyStimulus(4'b0100, 0, 0, 4'd0, 3'b000, "coin5");
        applyStimulus(4'b0000, 0, 0, 4'd0, 3'b000, "vend");
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 0, 0, 4'd0, 3'b000, "hold no ack");
        applyStimulus(4'b0000, 0, 0, 4'd0, 3'b001, "wrong ack");
        applyStimulus(4'b0000, 0, 0, 4'd0, 3'b010, "ack 2");
        drainPayout("change tail");

        $display("[TB] directed sold out and restock");
        applyStimulus(4'b0001, 0, 0, 4'd0, 3'b000, "coin while sold out");
        applyStimulus(4'b0000, 0, 1, 4'd3, 3'b000, "restock 3");

        $display("[TB] directed overflow, illegal coin, refund");
        applyStimulus(4'b1000, 0, 0, 4'd0, 3'b000, "coin10 again");
        applyStimulus(4'b1000, 0, 0, 4'd0, 3'b000, "overflow coin");
        checkOutput("overflow credit held", int'(bus.credit), 10);
        applyStimulus(4'b0011, 0, 0, 4'd0, 3'b000, "multi-hot coin");
        applyStimulus(4'b0000, 1, 0, 4'd0, 3'b000, "cancel");
        drainPayout("refund 10");
        applyStimulus(4'b0010, 0, 0, 4'd0, 3'b000, "coin2");
        applyStimulus(4'b0001, 1, 0, 4'd0, 3'b000, "coin with cancel");
        drainPayout("refund 2");

        $display("[TB] directed reset during change");
        applyStimulus(4'b1000, 0, 0, 4'd0, 3'b000, "pre-reset coin10");
        applyStimulus(4'b0100, 0, 0, 4'd0, 3'b000, "pre-reset coin5");
        applyStimulus(4'b0000, 0, 0, 4'd0, 3'b000, "pre-reset vend");
        applyStimulus(4'b0000, 0, 0, 4'd0, 3'b000, "pre-reset request");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid-change reset chg_req", int'(bus.chg_req), 0);
        checkOutput("mid-change reset credit",  int'(bus.credit),  0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        compareAll("after reset");

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 30)      coin = 4'b0001 << $urandom_range(0, 3);
            else if (r < 34) coin = 4'($urandom_range(0, 15));
            else             coin = 4'b0000;
            cancel  = ($urandom_range(0, 99) < 6);
            restock = ($urandom_range(0, 99) < 4);
            qty     = 4'($urandom_range(0, 15));
            if (expReq() != 3'b000 && $urandom_range(0, 1) == 1) ack = expReq();
            else if ($urandom_range(0, 7) == 0)                  ack = 3'($urandom_range(0, 7));
            else                                                  ack = 3'b000;
            applyStimulus(coin, cancel, restock, qty, ack, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
